// File: rtl/ps2_kbd_pkg.sv
// Shared scancode, ASCII and FSM state definitions for the PS/2 set-2 keyboard decoder.
package ps2_kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_TAB    = 8'h0D;

   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_TAB   = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_e;

endpackage

// File: rtl/scan2ascii_lut.sv
// Combinational set-2 scancode to ASCII lookup; letters honour shift XOR caps, symbols honour shift only.
module scan2ascii_lut
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0] ENTER_CODE = 8'd10,
  parameter logic [7:0] BS_CODE    = 8'd8
) (
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic       hit_o,
  output logic [7:0] ascii_o
);

  // Entry layout: {is_letter, base_char, shifted_char}; a zero base marks an unmapped code.
  logic [16:0] entry;

  always_comb begin
    entry = '0;
    case (code_i)
      8'h1C: entry = {1'b1, "a", "A"};
      8'h32: entry = {1'b1, "b", "B"};
      8'h21: entry = {1'b1, "c", "C"};
      8'h23: entry = {1'b1, "d", "D"};
      8'h24: entry = {1'b1, "e", "E"};
      8'h2B: entry = {1'b1, "f", "F"};
      8'h34: entry = {1'b1, "g", "G"};
      8'h33: entry = {1'b1, "h", "H"};
      8'h43: entry = {1'b1, "i", "I"};
      8'h3B: entry = {1'b1, "j", "J"};
      8'h42: entry = {1'b1, "k", "K"};
      8'h4B: entry = {1'b1, "l", "L"};
      8'h3A: entry = {1'b1, "m", "M"};
      8'h31: entry = {1'b1, "n", "N"};
      8'h44: entry = {1'b1, "o", "O"};
      8'h4D: entry = {1'b1, "p", "P"};
      8'h15: entry = {1'b1, "q", "Q"};
      8'h2D: entry = {1'b1, "r", "R"};
      8'h1B: entry = {1'b1, "s", "S"};
      8'h2C: entry = {1'b1, "t", "T"};
      8'h3C: entry = {1'b1, "u", "U"};
      8'h2A: entry = {1'b1, "v", "V"};
      8'h1D: entry = {1'b1, "w", "W"};
      8'h22: entry = {1'b1, "x", "X"};
      8'h35: entry = {1'b1, "y", "Y"};
      8'h1A: entry = {1'b1, "z", "Z"};
      8'h16: entry = {1'b0, "1", "!"};
      8'h1E: entry = {1'b0, "2", "@"};
      8'h26: entry = {1'b0, "3", "#"};
      8'h25: entry = {1'b0, "4", "$"};
      8'h2E: entry = {1'b0, "5", "%"};
      8'h36: entry = {1'b0, "6", "^"};
      8'h3D: entry = {1'b0, "7", "&"};
      8'h3E: entry = {1'b0, "8", "*"};
      8'h46: entry = {1'b0, "9", "("};
      8'h45: entry = {1'b0, "0", ")"};
      8'h0E: entry = {1'b0, 8'h60, 8'h7E};
      8'h4E: entry = {1'b0, "-", "_"};
      8'h55: entry = {1'b0, "=", "+"};
      8'h54: entry = {1'b0, "[", "{"};
      8'h5B: entry = {1'b0, "]", "}"};
      8'h5D: entry = {1'b0, 8'h5C, 8'h7C};
      8'h4C: entry = {1'b0, ";", ":"};
      8'h52: entry = {1'b0, 8'h27, 8'h22};
      8'h41: entry = {1'b0, ",", "<"};
      8'h49: entry = {1'b0, ".", ">"};
      8'h4A: entry = {1'b0, "/", "?"};
      SC_SPACE: entry = {1'b0, ASC_SPACE, ASC_SPACE};
      SC_ENTER: entry = {1'b0, ENTER_CODE, ENTER_CODE};
      SC_BKSP:  entry = {1'b0, BS_CODE, BS_CODE};
      SC_TAB:   entry = {1'b0, ASC_TAB, ASC_TAB};
      default:  entry = '0;
    endcase
  end

  assign hit_o = (entry[15:8] != 8'h00);

  always_comb begin
    if (entry[16]) ascii_o = (shift_i ^ caps_i) ? entry[7:0] : entry[15:8];
    else           ascii_o = shift_i ? entry[7:0] : entry[15:8];
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scancode stream to ASCII strobe for the text-mode video memory.
// Optional REPEAT_FILTER_EN suppresses typematic repeats of the last made key until its break.
module ps2_ascii_decoder
   import ps2_kbd_pkg::*;
#(
   parameter logic [7:0] ENTER_CODE = 8'd10,
   parameter logic [7:0] BS_CODE    = 8'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_data,
   input  logic       scan_valid,
   output logic [7:0] key_in,
   output logic       p_valid,
   output logic       shift_o,
   output logic       caps_o,
   output logic [1:0] state_o
);

   ps2_state_e state_q;
   logic [7:0] key_q;
   logic       p_valid_q;
   logic       lshift_q;
   logic       rshift_q;
   logic       caps_q;
   logic       caps_held_q;
   logic       lut_hit;
   logic [7:0] lut_ascii;
   logic       emit_ok;

   scan2ascii_lut #(
      .ENTER_CODE (ENTER_CODE),
      .BS_CODE    (BS_CODE)
   ) u_lut (
      .code_i  (scan_data),
      .shift_i (lshift_q | rshift_q),
      .caps_i  (caps_q),
      .hit_o   (lut_hit),
      .ascii_o (lut_ascii)
   );

`ifdef REPEAT_FILTER_EN
   logic [7:0] last_code_q;
   logic       last_vld_q;

   assign emit_ok = !(last_vld_q && (last_code_q == scan_data));

   // Armed by an emitted make, disarmed by the break of that same code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_code_q <= 8'h00;
         last_vld_q  <= 1'b0;
      end else if (scan_valid) begin
         if (state_q == ST_IDLE && lut_hit && emit_ok) begin
            last_code_q <= scan_data;
            last_vld_q  <= 1'b1;
         end else if (state_q == ST_BRK && scan_data == last_code_q) begin
            last_vld_q  <= 1'b0;
         end
      end
   end
`else
   assign emit_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         key_q       <= 8'h00;
         p_valid_q   <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         caps_q      <= 1'b0;
         caps_held_q <= 1'b0;
      end else begin
         p_valid_q <= 1'b0;
         if (scan_valid) begin
            case (state_q)
               ST_IDLE: begin
                  if (scan_data == SC_BREAK) begin
                     state_q <= ST_BRK;
                  end else if (scan_data == SC_EXT) begin
                     state_q <= ST_EXT;
                  end else if (scan_data == SC_LSHIFT) begin
                     lshift_q <= 1'b1;
                  end else if (scan_data == SC_RSHIFT) begin
                     rshift_q <= 1'b1;
                  end else if (scan_data == SC_CAPS) begin
                     // Typematic repeats of Caps Lock must not re-toggle.
                     if (!caps_held_q) caps_q <= ~caps_q;
                     caps_held_q <= 1'b1;
                  end else if (lut_hit && emit_ok) begin
                     key_q     <= lut_ascii;
                     p_valid_q <= 1'b1;
                  end
               end
               ST_BRK: begin
                  state_q <= (scan_data == SC_EXT) ? ST_EXT : ST_IDLE;
                  if (scan_data == SC_LSHIFT) lshift_q    <= 1'b0;
                  if (scan_data == SC_RSHIFT) rshift_q    <= 1'b0;
                  if (scan_data == SC_CAPS)   caps_held_q <= 1'b0;
               end
               ST_EXT: begin
                  state_q <= (scan_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                  if (scan_data == SC_ENTER) begin
                     key_q     <= ENTER_CODE;
                     p_valid_q <= 1'b1;
                  end
               end
               ST_EXT_BRK: state_q <= ST_IDLE;
               default:    state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign key_in  = key_q;
   assign p_valid = p_valid_q;
   assign shift_o = lshift_q | rshift_q;
   assign caps_o  = caps_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Self-checking bench for ps2_ascii_decoder: directed steps followed by random scancode streams.
module tb_ps2_ascii_decoder;
  import ps2_kbd_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_data = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] key_in;
  logic       p_valid;
  logic       shift_o;
  logic       caps_o;
  logic [1:0] state_o;

  ps2_ascii_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .key_in     (key_in),
    .p_valid    (p_valid),
    .shift_o    (shift_o),
    .caps_o     (caps_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int strobes  = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: prefix mode (0 plain, 1 after F0, 2 after E0, 3 after E0 F0) plus key state.
  int         m_mode;
  logic       m_ls, m_rs, m_caps, m_caps_down, m_last_vld;
  logic [7:0] m_last, m_key;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                                 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] sym_base [20] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                                8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sym_shift [20] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                                 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h1A, 8'h15, 8'h16, 8'h45, 8'h4E, 8'h0E, 8'h52, 8'h29,
                            8'h5A, 8'h66, 8'h0D, 8'h05, 8'hE1, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0,
                            8'hE0, 8'h5D, 8'h4A, 8'h14};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model_map(input logic [7:0] b, input logic sh, input logic cp);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) return {1'b1, 8'(((sh ^ cp) ? 65 : 97) + i)};
    for (int i = 0; i < 20; i++)
      if (sym_codes[i] == b) return {1'b1, sh ? sym_shift[i] : sym_base[i]};
    case (b)
      8'h0E:   return {1'b1, sh ? 8'h7E : 8'h60};
      8'h29:   return {1'b1, 8'h20};
      8'h5A:   return {1'b1, 8'd10};
      8'h66:   return {1'b1, 8'd8};
      8'h0D:   return {1'b1, 8'h09};
      default: return 9'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_caps_down = 0;
    m_last_vld = 0; m_last = 8'h00; m_key = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [7:0] b, output logic emit, output logic [7:0] ch);
    logic [8:0] r;
    emit = 1'b0;
    ch   = 8'h00;
    case (m_mode)
      0: begin
        if (b == 8'hF0) m_mode = 1;
        else if (b == 8'hE0) m_mode = 2;
        else if (b == 8'h12) m_ls = 1;
        else if (b == 8'h59) m_rs = 1;
        else if (b == 8'h58) begin
          if (!m_caps_down) m_caps = ~m_caps;
          m_caps_down = 1;
        end else begin
          r = model_map(b, m_ls | m_rs, m_caps);
`ifdef REPEAT_FILTER_EN
          if (r[8] && !(m_last_vld && m_last == b)) begin
            emit = 1'b1; ch = r[7:0]; m_last = b; m_last_vld = 1;
          end
`else
          if (r[8]) begin emit = 1'b1; ch = r[7:0]; end
`endif
        end
      end
      1: begin
        m_mode = (b == 8'hE0) ? 2 : 0;
        if (b == 8'h12) m_ls = 0;
        if (b == 8'h59) m_rs = 0;
        if (b == 8'h58) m_caps_down = 0;
        if (b == m_last) m_last_vld = 0;
      end
      2: begin
        m_mode = (b == 8'hF0) ? 3 : 0;
        if (b == 8'h5A) begin emit = 1'b1; ch = 8'd10; end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_outputs(input logic e);
    check("p_valid", 8'(p_valid), 8'(e));
    if (p_valid) strobes++;
    if (e && exp_q.size() > 0) check("key_in", key_in, exp_q.pop_front());
    check("key_hold", key_in, m_key);
    check("shift_o", 8'(shift_o), 8'(m_ls | m_rs));
    check("caps_o", 8'(caps_o), 8'(m_caps));
  endtask

  // Drives one byte for exactly one clock; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    logic e;
    logic [7:0] c;
    @(negedge clk);
    scan_data  = b;
    scan_valid = 1'b1;
    model_step(b, e, c);
    if (e) begin exp_q.push_back(c); m_key = c; end
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    check_outputs(1'b0 | e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outputs(1'b0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_key", key_in, 8'h00);
    check("rst_pvalid", 8'(p_valid), 8'h00);
    check("rst_shift", 8'(shift_o), 8'h00);
    check("rst_caps", 8'(caps_o), 8'h00);
    check("rst_state", 8'(state_o), 8'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;

    send(8'h1C); check("a_make", key_in, 8'h61);
    idle(1);
    strobes = 0;
    send(8'hF0); send(8'h1C); idle(1);
    check("a_break_silent", 8'(strobes), 8'd0);

    send(8'h12); check("shift_held", 8'(shift_o), 8'h01);
    send(8'h1C); check("A_shift", key_in, 8'h41);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("shift_released", 8'(shift_o), 8'h00);
    send(8'h1C); check("a_after_shift", key_in, 8'h61);
    send(8'hF0); send(8'h1C);

    send(8'h58); send(8'h58); check("caps_repeat_once", 8'(caps_o), 8'h01);
    send(8'hF0); send(8'h58);
    send(8'h1C); check("A_caps", key_in, 8'h41);
    send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h1C); check("a_caps_shift", key_in, 8'h61);
    send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h16); check("bang", key_in, 8'h21);
    send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    check("caps_off", 8'(caps_o), 8'h00);

    send(8'h5A); check("enter", key_in, 8'h0A);
    send(8'hE0); send(8'h5A); check("kp_enter", key_in, 8'h0A);
    send(8'h66); check("bksp", key_in, 8'h08);
    strobes = 0;
    send(8'hE0); send(8'hF0); send(8'h5A); send(8'h05); idle(1);
    check("ext_break_f1_silent", 8'(strobes), 8'd0);

    strobes = 0;
    send(8'h1C); send(8'h1C); send(8'h1C); idle(1);
`ifdef REPEAT_FILTER_EN
    check("repeat_strobes", 8'(strobes), 8'd1);
`else
    check("repeat_strobes", 8'(strobes), 8'd3);
`endif
    strobes = 0;
    send(8'hF0); send(8'h1C); send(8'h1C); idle(1);
    check("rearm_strobes", 8'(strobes), 8'd1);

    send(8'h12); send(8'hF0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_key", key_in, 8'h00);
    check("mid_rst_pvalid", 8'(p_valid), 8'h00);
    check("mid_rst_shift", 8'(shift_o), 8'h00);
    check("mid_rst_caps", 8'(caps_o), 8'h00);
    check("mid_rst_state", 8'(state_o), 8'(ST_IDLE));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C); check("a_after_rst", key_in, 8'h61);
    send(8'hF0); send(8'h1C);

    for (int i = 0; i < 600; i++) begin
      send(pool[$urandom_range(0, 23)]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
